edge_scan_lr: RTL

//  Scans a shape row by row, from row mostTop down to row mostBottom, and finds its left and right extent.
//  On each row it walks outward from column midPix until it hits a background pixel or the image border.

---
 rtl/edge_scan_pkg.sv | 21 ++
 rtl/pix_addr_xlate.sv | 15 +
 rtl/edge_scan_lr.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/edge_scan_pkg.sv
// Shared definitions for the left/right edge scanner: FSM state encoding,
// default background threshold and the background test.
package edge_scan_pkg;

    localparam int unsigned THRESHOLD_DEF = 0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ROW_INIT = 3'd1;
    localparam state_t ST_SEED_RD  = 3'd2;
    localparam state_t ST_L_RD     = 3'd3;
    localparam state_t ST_R_RD     = 3'd4;
    localparam state_t ST_NEXT_ROW = 3'd5;
    localparam state_t ST_DONE     = 3'd6;

    function automatic logic is_bg(input int unsigned pix, input int unsigned thr);
        return pix <= thr;
    endfunction

endpackage

// File: rtl/pix_addr_xlate.sv
// Combinational pixel-to-address translator for a row-major image: addr = y*IMG_W + x.
module pix_addr_xlate #(
    parameter int IMG_W  = 6,
    parameter int X_W    = 3,
    parameter int Y_W    = 3,
    parameter int ADDR_W = 6
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr
);

    assign addr = ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);

endmodule

// File: rtl/edge_scan_lr.sv
// Row-by-row left/right extent finder: walks outward from a seed column on each
// row through one shared, fixed-latency read port.
module edge_scan_lr
    import edge_scan_pkg::*;
#(
    parameter int          IMG_W     = 6,
    parameter int          IMG_H     = 6,
    parameter int          COL_W     = 3,
    parameter int unsigned THRESHOLD = THRESHOLD_DEF,
    parameter int          RD_LAT    = 1,
    localparam int         X_W       = $clog2(IMG_W),
    localparam int         Y_W       = $clog2(IMG_H),
    localparam int         ADDR_W    = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [Y_W-1:0]    mostTop,
    input  logic [Y_W-1:0]    mostBottom,
    input  logic [X_W-1:0]    midPix,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [COL_W-1:0]  mem_rdata,
    output logic [X_W-1:0]    mostLeft,
    output logic [X_W-1:0]    mostRight,
    output logic              found,
    output logic              err,
    output logic              busy,
    output logic              done
);

    localparam int               LAT_W   = $clog2(RD_LAT + 1);
    localparam logic [X_W-1:0]   X_MAX   = X_W'(IMG_W - 1);
    localparam logic [X_W-1:0]   X_ONE   = X_W'(1);
    localparam logic [LAT_W-1:0] LAT_END = LAT_W'(RD_LAT);

    state_t            state, stateNext;
    logic [Y_W-1:0]    rowY, bottomLat;
    logic [X_W-1:0]    midLat, xl, xr, xlNext, xrNext, rdX;
    logic [LAT_W-1:0]  lat;
    logic [ADDR_W-1:0] rdAddr;
    logic              accept, reqErr, latHit, pixBg;
    logic              loadAddr, scanLeft, scanRight, rowDone;

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign accept = (state == ST_IDLE) && start;
    assign reqErr = (mostTop > mostBottom) || (32'(mostBottom) >= 32'(IMG_H))
                    || (32'(midPix) >= 32'(IMG_W));
    assign latHit = (lat == LAT_END);
    assign pixBg  = is_bg(32'(mem_rdata), THRESHOLD);

    pix_addr_xlate #(
        .IMG_W (IMG_W),
        .X_W   (X_W),
        .Y_W   (Y_W),
        .ADDR_W(ADDR_W)
    ) uXlate (
        .x   (rdX),
        .y   (rowY),
        .addr(rdAddr)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block infers a latch.
        stateNext = state;
        xlNext    = xl;
        xrNext    = xr;
        rdX       = xl;
        loadAddr  = 1'b0;
        scanLeft  = 1'b0;
        scanRight = 1'b0;
        rowDone   = 1'b0;
        case (state)
            ST_IDLE:     if (accept) stateNext = reqErr ? ST_DONE : ST_ROW_INIT;
            ST_ROW_INIT: begin
                xlNext    = midLat;
                xrNext    = midLat;
                rdX       = midLat;
                loadAddr  = 1'b1;
                stateNext = ST_SEED_RD;
            end
            ST_SEED_RD: if (latHit) begin
                if (pixBg) stateNext = ST_NEXT_ROW;
                else       scanLeft  = 1'b1;
            end
            ST_L_RD: if (latHit) begin
                if (pixBg) scanRight = 1'b1;
                else begin
                    xlNext   = xl - X_ONE;
                    scanLeft = 1'b1;
                end
            end
            ST_R_RD: if (latHit) begin
                if (pixBg) rowDone = 1'b1;
                else begin
                    xrNext    = xr + X_ONE;
                    scanRight = 1'b1;
                end
            end
            ST_NEXT_ROW: stateNext = (rowY == bottomLat) ? ST_DONE : ST_ROW_INIT;
            ST_DONE:     stateNext = ST_IDLE;
            default:     stateNext = ST_IDLE;
        endcase

        // Border checks happen before a read is issued, so x never wraps past 0 or IMG_W-1.
        if (scanLeft) begin
            if (xlNext == '0) scanRight = 1'b1;
            else begin
                rdX       = xlNext - X_ONE;
                loadAddr  = 1'b1;
                stateNext = ST_L_RD;
            end
        end
        if (scanRight) begin
            if (xrNext == X_MAX) rowDone = 1'b1;
            else begin
                rdX       = xrNext + X_ONE;
                loadAddr  = 1'b1;
                stateNext = ST_R_RD;
            end
        end
        if (rowDone) stateNext = ST_NEXT_ROW;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            mem_addr  <= '0;
            mostLeft  <= X_MAX;
            mostRight <= '0;
            found     <= 1'b0;
            err       <= 1'b0;
            rowY      <= '0;
            bottomLat <= '0;
            midLat    <= '0;
            xl        <= '0;
            xr        <= '0;
            lat       <= '0;
        end else begin
            state <= stateNext;
            xl    <= xlNext;
            xr    <= xrNext;

            if (loadAddr) begin
                mem_addr <= rdAddr;
                lat      <= '0;
            end else if (!latHit) begin
                lat <= lat + LAT_W'(1);
            end

            if (accept) begin
                rowY      <= mostTop;
                bottomLat <= mostBottom;
                midLat    <= midPix;
                mostLeft  <= X_MAX;
                mostRight <= '0;
                found     <= 1'b0;
                err       <= reqErr;
            end else if (state == ST_NEXT_ROW && rowY != bottomLat) begin
                rowY <= rowY + Y_W'(1);
            end

            if (rowDone) begin
                if (xlNext < mostLeft)  mostLeft  <= xlNext;
                if (xrNext > mostRight) mostRight <= xrNext;
                found <= 1'b1;
            end
        end
    end

endmodule
